// File: rtl/adc_xy_xform.sv
// ADC X/Y coordinate transform: mirror, fixed-point scale/clamp, optional axis swap,
// delayed color alignment, duplicate suppression and a first-word-fall-through output FIFO.
module adc_xy_xform #(
    parameter int DATA_WIDTH  = 10,
    parameter int COLOR_WIDTH = 3,
    parameter int NUM_WIDTH   = 4,
    parameter int MAX_DELAY   = 15,
    parameter int ADDR_WIDTH  = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    input  logic [DATA_WIDTH-1:0]            in_x,
    input  logic [DATA_WIDTH-1:0]            in_y,
    input  logic [COLOR_WIDTH-1:0]           in_color,
    input  logic                             cfg_mirror_x,
    input  logic                             cfg_mirror_y,
    input  logic                             cfg_swap_xy,
    input  logic                             cfg_dedup,
    input  logic [NUM_WIDTH-1:0]             cfg_num_x,
    input  logic [NUM_WIDTH-1:0]             cfg_num_y,
    input  logic [3:0]                       cfg_shift_x,
    input  logic [3:0]                       cfg_shift_y,
    input  logic [$clog2(MAX_DELAY+1)-1:0]   cfg_color_delay,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH-1:0]            out_x,
    output logic [DATA_WIDTH-1:0]            out_y,
    output logic [COLOR_WIDTH-1:0]           out_color,
    output logic [15:0]                      drop_count
);

    localparam int PW    = DATA_WIDTH + NUM_WIDTH;
    localparam int DLW   = $clog2(MAX_DELAY + 1);
    localparam int FW    = 2 * DATA_WIDTH + COLOR_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [DATA_WIDTH-1:0] VMAX = '1;

    // Stage 1: mirror
    logic                  v1;
    logic [DATA_WIDTH-1:0] x1, y1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            x1 <= '0;
            y1 <= '0;
        end else begin
            v1 <= in_valid;
            x1 <= cfg_mirror_x ? VMAX - in_x : in_x;
            y1 <= cfg_mirror_y ? VMAX - in_y : in_y;
        end
    end

    // Stage 2: full-width product
    logic          v2;
    logic [PW-1:0] px, py;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2 <= 1'b0;
            px <= '0;
            py <= '0;
        end else begin
            v2 <= v1;
            px <= PW'(x1) * PW'(cfg_num_x);
            py <= PW'(y1) * PW'(cfg_num_y);
        end
    end

    // Stage 3 combinational scale/clamp
    logic [PW-1:0]         sx_full, sy_full;
    logic [DATA_WIDTH-1:0] sx, sy;

    always_comb begin
        sx_full = px >> cfg_shift_x;
        sy_full = py >> cfg_shift_y;
        sx = (sx_full > PW'(VMAX)) ? VMAX : sx_full[DATA_WIDTH-1:0];
        sy = (sy_full > PW'(VMAX)) ? VMAX : sy_full[DATA_WIDTH-1:0];
    end

    // Color delay line; tap 1+d lines up with stage 3 when d extra cycles are requested
    logic [COLOR_WIDTH-1:0] color_sr [0:MAX_DELAY+1];
    logic [DLW-1:0]         eff_delay;
    logic [DLW:0]           tap;

    generate
        if (((1 << DLW) - 1) > MAX_DELAY) begin : g_clamp
            assign eff_delay = (cfg_color_delay > DLW'(MAX_DELAY)) ? DLW'(MAX_DELAY) : cfg_color_delay;
        end else begin : g_noclamp
            assign eff_delay = cfg_color_delay;
        end
    endgenerate

    assign tap = (DLW + 1)'(eff_delay) + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i <= MAX_DELAY + 1; i++) color_sr[i] <= '0;
        end else begin
            color_sr[0] <= in_color;
            for (int unsigned i = 1; i <= MAX_DELAY + 1; i++) color_sr[i] <= color_sr[i-1];
        end
    end

    // Stage 3 registers
    logic                   v3;
    logic [DATA_WIDTH-1:0]  x3, y3;
    logic [COLOR_WIDTH-1:0] c3;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v3 <= 1'b0;
            x3 <= '0;
            y3 <= '0;
            c3 <= '0;
        end else begin
            v3 <= v2;
            x3 <= cfg_swap_xy ? sy : sx;
            y3 <= cfg_swap_xy ? sx : sy;
            c3 <= color_sr[tap];
        end
    end

    // Candidate selection with duplicate suppression
    logic [FW-1:0] cand, prev;
    logic          wr_req;

    assign cand   = {x3, y3, c3};
    assign wr_req = v3 && (|c3) && (!cfg_dedup || (cand != prev));

    always_ff @(posedge clk) begin
        if (!rst_n)  prev <= '0;
        else if (v3) prev <= cand;
    end

    // Output FIFO, first-word-fall-through
    logic [FW-1:0]       mem [DEPTH];
    logic [ADDR_WIDTH:0] wr_ptr, rd_ptr;
    logic                empty, full, push, pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                   (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    assign push  = wr_req && !full;
    assign pop   = !empty && out_ready;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[ADDR_WIDTH-1:0]] <= cand;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            drop_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (wr_req && full && (drop_count != '1)) drop_count <= drop_count + 1'b1;
        end
    end

    assign out_valid = !empty;
    assign {out_x, out_y, out_color} = mem[rd_ptr[ADDR_WIDTH-1:0]];

endmodule

// File: tb/tb_adc_xy_xform.sv
// Scoreboard bench for adc_xy_xform: a reference model queues expected pixels as samples are driven.
module tb_adc_xy_xform;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [9:0]  in_x, in_y;
    logic [2:0]  in_color;
    logic        cfg_mirror_x, cfg_mirror_y, cfg_swap_xy, cfg_dedup;
    logic [3:0]  cfg_num_x, cfg_num_y, cfg_shift_x, cfg_shift_y;
    logic [3:0]  cfg_color_delay;
    logic        out_valid, out_ready;
    logic [9:0]  out_x, out_y;
    logic [2:0]  out_color;
    logic [15:0] drop_count;

    adc_xy_xform #(.DATA_WIDTH(10), .COLOR_WIDTH(3), .NUM_WIDTH(4), .MAX_DELAY(15), .ADDR_WIDTH(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_x(in_x), .in_y(in_y), .in_color(in_color),
        .cfg_mirror_x(cfg_mirror_x), .cfg_mirror_y(cfg_mirror_y), .cfg_swap_xy(cfg_swap_xy),
        .cfg_dedup(cfg_dedup), .cfg_num_x(cfg_num_x), .cfg_num_y(cfg_num_y),
        .cfg_shift_x(cfg_shift_x), .cfg_shift_y(cfg_shift_y), .cfg_color_delay(cfg_color_delay),
        .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
        .out_color(out_color), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_pop  = 0;
    int drop_exp = 0;
    logic [22:0] q [$];
    logic [2:0]  hist [$];
    logic [22:0] mprev = '0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [9:0] scale(input logic [9:0] v, input logic m,
                                         input logic [3:0] num, input logic [3:0] sh);
        int unsigned mv, p;
        mv = m ? 1023 - int'(v) : int'(v);
        p  = (mv * num) >> sh;
        return (p > 1023) ? 10'd1023 : 10'(p);
    endfunction

    task automatic model(input logic [9:0] x, input logic [9:0] y);
        logic [9:0]  sx, sy, ox, oy;
        logic [2:0]  col;
        logic [22:0] cand;
        int d;
        d   = int'(cfg_color_delay);
        col = (hist.size() > d) ? hist[hist.size() - 1 - d] : 3'b000;
        sx  = scale(x, cfg_mirror_x, cfg_num_x, cfg_shift_x);
        sy  = scale(y, cfg_mirror_y, cfg_num_y, cfg_shift_y);
        ox  = cfg_swap_xy ? sy : sx;
        oy  = cfg_swap_xy ? sx : sy;
        cand = {ox, oy, col};
        if (col != 0 && (!cfg_dedup || cand != mprev)) begin
            if (q.size() >= 8) begin
                if (drop_exp < 65535) drop_exp++;
            end else q.push_back(cand);
        end
        mprev = cand;
    endtask

    task automatic drive(input logic v, input logic [9:0] x, input logic [9:0] y, input logic [2:0] c);
        in_valid = v; in_x = x; in_y = y; in_color = c;
        hist.push_back(c);
        if (v) model(x, y);
        @(posedge clk); #1;
    endtask

    // Count edges from the sample's capture until out_valid rises.
    task automatic wait_out(input int exp, input string tag, input logic v,
                            input logic [9:0] x, input logic [9:0] y);
        int e = 1;
        while (!out_valid && e < 40) begin
            drive(v, x, y, 3'b000);
            e++;
        end
        check(tag, e, exp);
    endtask

    task automatic drain();
        int n = 0;
        repeat (8) drive(1'b0, 10'd0, 10'd0, 3'b000);
        while (q.size() > 0 && n < 50) begin
            drive(1'b0, 10'd0, 10'd0, 3'b000);
            n++;
        end
        if (q.size() > 0) check("drain", q.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_color = '0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        q.delete(); hist.delete(); mprev = '0; drop_exp = 0;
    endtask

    task automatic set_cfg(input logic mx, input logic my, input logic sw, input logic dd,
                           input logic [3:0] nx, input logic [3:0] ny,
                           input logic [3:0] shx, input logic [3:0] shy, input logic [3:0] dl);
        cfg_mirror_x = mx; cfg_mirror_y = my; cfg_swap_xy = sw; cfg_dedup = dd;
        cfg_num_x = nx; cfg_num_y = ny; cfg_shift_x = shx; cfg_shift_y = shy; cfg_color_delay = dl;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) check("unexpected_pixel", 1, 0);
            else begin
                logic [22:0] e;
                e = q.pop_front();
                check("pix_x", out_x, e[22:13]);
                check("pix_y", out_y, e[12:3]);
                check("pix_color", out_color, e[2:0]);
                n_pop++;
            end
        end
    end

    initial begin
        int p0;
        in_x = '0; in_y = '0; out_ready = 1'b1;
        set_cfg(1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0);
        do_reset();
        check("rst_out_valid", out_valid, 0);
        check("rst_drop_count", drop_count, 0);

        // Mirror/scale with 4-edge latency
        set_cfg(1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 4'd3, 4'd2, 4'd2, 4'd0);
        drive(1'b1, 10'd100, 10'd200, 3'b100);
        wait_out(4, "latency", 1'b0, 10'd0, 10'd0);
        drain();

        // Color delay 5: pulse emerges 9 edges later
        set_cfg(1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1, 4'd0, 4'd0, 4'd5);
        p0 = n_pop;
        repeat (8) drive(1'b1, 10'd10, 10'd20, 3'b000);
        drive(1'b1, 10'd10, 10'd20, 3'b010);
        wait_out(9, "color_delay_latency", 1'b1, 10'd10, 10'd20);
        drain();
        check("color_delay_count", n_pop - p0, 1);

        // Dedup on/off with a held sample
        for (int dd = 1; dd >= 0; dd--) begin
            set_cfg(1'b0, 1'b1, 1'b0, dd[0], 4'd5, 4'd7, 4'd1, 4'd3, 4'd0);
            p0 = n_pop;
            repeat (10) drive(1'b1, 10'd300, 10'd400, 3'b011);
            drain();
            check(dd ? "dedup_on_count" : "dedup_off_count", n_pop - p0, dd ? 1 : 10);
        end

        // Randomised configurations
        for (int b = 0; b < 4; b++) begin
            set_cfg(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    4'($urandom), 4'($urandom), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)),
                    4'($urandom_range(0, 4)));
            for (int i = 0; i < 30; i++)
                drive(1'($urandom_range(0, 3) != 0), 10'($urandom), 10'($urandom), 3'($urandom));
            drain();
        end

        // Clamp with swap
        set_cfg(1'b0, 1'b0, 1'b1, 1'b0, 4'd15, 4'd15, 4'd0, 4'd0, 4'd0);
        drive(1'b1, 10'd1023, 10'd1, 3'b001);
        wait_out(4, "clamp_latency", 1'b0, 10'd0, 10'd0);
        drain();

        // FIFO full: 10 lit samples, 8 kept, 2 dropped
        set_cfg(1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0);
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) drive(1'b1, 10'(i * 7 + 1), 10'(i * 3 + 2), 3'b101);
        repeat (6) drive(1'b0, 10'd0, 10'd0, 3'b000);
        check("full_drop_count", drop_count, drop_exp);
        check("full_drop_two", drop_count, 2);
        check("full_out_valid", out_valid, 1);
        p0 = n_pop;
        out_ready = 1'b1;
        repeat (12) drive(1'b0, 10'd0, 10'd0, 3'b000);
        check("full_pop_count", n_pop - p0, 8);
        check("full_empty_after", out_valid, 0);

        // Reset with 5 buffered and 3 in flight
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) drive(1'b1, 10'(i + 50), 10'(i + 60), 3'b110);
        repeat (5) drive(1'b0, 10'd0, 10'd0, 3'b000);
        check("pre_rst_drop_count", drop_count, 2);
        for (int i = 0; i < 3; i++) drive(1'b1, 10'(i + 80), 10'(i + 90), 3'b111);
        do_reset();
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_drop_count", drop_count, 0);
        p0 = n_pop;
        out_ready = 1'b1;
        repeat (12) drive(1'b0, 10'd0, 10'd0, 3'b000);
        check("post_rst_no_pixel", n_pop - p0, 0);
        check("post_rst_idle_valid", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/adc_xy_xform.md
ADC_XY_XFORM -- requirements
Module: adc_xy_xform

Interface
Parameters:
REQ-001 DATA_WIDTH, default 10, meaning: X/Y sample width.
REQ-002 COLOR_WIDTH, default 3, meaning: color channel count, one bit per channel.
REQ-003 NUM_WIDTH, default 4, meaning: scale numerator width.
REQ-004 MAX_DELAY, default 15, meaning: maximum color delay in cycles.
REQ-005 ADDR_WIDTH, default 3, meaning: output FIFO depth is 2**ADDR_WIDTH.
Ports:
REQ-006 clk  in  1  the single clock; all logic runs on its rising edge.
REQ-007 rst_n  in  1  synchronous active-low reset.
REQ-008 in_valid  in  1  qualifies the in_x/in_y sample for this cycle.
REQ-009 in_x, in_y  in  DATA_WIDTH each  raw ADC coordinates.
REQ-010 in_color  in  COLOR_WIDTH  raw beam color; sampled every cycle regardless of in_valid.
REQ-011 cfg_mirror_x, cfg_mirror_y, cfg_swap_xy, cfg_dedup  in  1 each  mode controls.
REQ-012 cfg_num_x, cfg_num_y  in  NUM_WIDTH each  scale numerators.
REQ-013 cfg_shift_x, cfg_shift_y  in  4 each  scale denominator exponents, denominator = 2**shift.
REQ-014 cfg_color_delay  in  clog2(MAX_DELAY+1)  extra color delay in cycles.
REQ-015 out_valid  out  1 / out_ready  in  1  output handshake.
REQ-016 out_x, out_y  out  DATA_WIDTH each / out_color  out  COLOR_WIDTH  pixel fields.
REQ-017 drop_count  out  16  count of pixels lost to FIFO full, saturating.

Function
REQ-018 Stage 1 (registered): mirror, v' = (2**DATA_WIDTH-1) - v when the axis mirror bit is set, else v.
REQ-019 Stage 2 (registered): product p = v' * num at full width DATA_WIDTH+NUM_WIDTH, unsigned.
REQ-020 Stage 3 (registered): s = p >> shift, clamped to 2**DATA_WIDTH-1; when cfg_swap_xy=1 the scaled X drives the Y field and the scaled Y drives the X field.
REQ-021 in_valid travels with its sample through all three stages as valid_p3; no stall, one sample accepted per cycle.
REQ-022 Color path: stage-3 color equals in_color sampled exactly (3 + min(cfg_color_delay, MAX_DELAY)) cycles earlier.
REQ-023 The color delay line shifts every cycle, independent of in_valid.
REQ-024 Candidate = {x, y, color} at stage 3; prev register captures the candidate on every cycle with valid_p3=1.
REQ-025 Candidate is written when valid_p3=1, color != 0, and (cfg_dedup=0 or candidate != prev).
REQ-026 Output FIFO is first-word-fall-through; out_valid = not empty; pop on out_valid && out_ready.
REQ-027 Write while full is dropped even when a pop occurs in the same cycle; drop_count increments by 1 and holds at 16'hFFFF.
REQ-028 Pop while empty has no effect.
REQ-029 Simultaneous push and pop when neither full nor empty leaves the occupancy unchanged.
REQ-030 Latency: sample on edge N appears on out_* with out_valid=1 after edge N+4, provided the FIFO was empty.
REQ-031 cfg_* are sampled combinationally at the stage that uses them; a change affects samples entering that stage on the next edge; there is no flush.
REQ-032 out_* fields hold their last value when out_valid=0; they are don't-care.

Reset
REQ-033 On rst_n=0 at an edge, the block clears all stage valids, prev, the color delay line, FIFO pointers and drop_count to 0; out_valid=0 at the next cycle.
REQ-034 Reset mid-stream discards all in-flight and buffered pixels; no partial pixel is emitted afterward.

Verification
REQ-035 Setup: num_x=num_y=3, shift=2, mirror_x=1, delay=0; input x=100, y=200, color=3'b100 for one cycle -> one pixel after 4 edges: x=692, y=150, color=3'b100.
REQ-036 Setup: delay=5, x/y constant 10/20, color=3'b010 pulsed at cycle 0 -> exactly one pixel, color 3'b010, emitted 9 edges after the pulse.
REQ-037 Setup: the same lit sample held for 10 cycles -> with cfg_dedup=1, 1 pixel; with cfg_dedup=0, 10 pixels.
REQ-038 Setup: out_ready=0, 10 distinct lit samples -> 8 buffered in order, drop_count=2; raise out_ready -> 8 pops in order, out_valid then 0.
REQ-039 Setup: num=15, shift=0, x=1023, y=1, swap_xy=1 -> out_x=15, out_y=1023 (clamped).
REQ-040 Setup: assert reset with 5 buffered pixels plus 3 pixels in flight -> out_valid=0 and drop_count=0 after reset; no stale pixel emitted.
